tlb: RTL and testbench
======================

# tlb

Fully associative joint TLB that answers the CP0 TLB-management interface (TLBWI write, TLBR read, TLBP probe) and translates instruction and data virtual addresses for the fetch and memory stages. It holds `TLB_ENTRIES_NUM` dual-page entries in `tlb_entry_t` format and applies the fixed kseg0/kseg1 mapping. Translation results are registered, so each lookup port has one-cycle latency and the stages hold their request until a stall is released.

## Interface
- `TLB_ENTRIES` — default `` `TLB_ENTRIES_NUM `` (16) — number of entries; must be a power of two.
- `clk`  in  1 — clock; the block uses one clock.
- `reset`  in  1 — reset; synchronous, active-high.
- `tlb_asid`  in  8 — current ASID from EntryHi.
- `tlbrw_index`  in  `tlb_index_t` — entry index for TLBR/TLBWI.
- `tlbrw_we`  in  1 — TLBWI write strobe.
- `tlbrw_wdata`  in  `tlb_entry_t` — entry to write.
- `tlbrw_rdata`  out  `tlb_entry_t` — entry at `tlbrw_index`; combinational.
- `tlbp_entry_hi`  in  32 — EntryHi value for the probe.
- `tlbp_index`  out  32 — probe result; combinational.
- `kseg0_uncached`  in  1 — kseg0 cacheability (Config0.K0 != 3).
- `inst_req`  in  1 — instruction lookup request.
- `inst_stall`  in  1 — freezes the instruction result registers.
- `inst_vaddr`  in  `virt_t`.
- `inst_paddr`  out  `phys_t`.
- `inst_uncached`, `inst_refill`, `inst_invalid`  out  1 each.
- `data_req`, `data_stall`, `data_wr`  in  1 each — `data_wr`=1 means store.
- `data_vaddr`  in  `virt_t`.
- `data_paddr`  out  `phys_t`.
- `data_uncached`, `data_refill`, `data_invalid`, `data_mod`  out  1 each.

## Operation
- **Storage:** `TLB_ENTRIES` registers of `tlb_entry_t`.
  - On reset, every entry's `v0`, `v1` and `G` clear. Other fields are don't-care.
  - On `tlbrw_we`, `entry[tlbrw_index] <= tlbrw_wdata`.
- **Match for entry i, given vaddr and asid:** `vpn2 == vaddr[31:13]` and (`G` or `asid` field == asid).
- **Page select:** `vaddr[12]`=0 selects the even page (pfn0/c0/d0/v0); =1 selects the odd page (pfn1/c1/d1/v1).
- **Read:** `tlbrw_rdata = entry[tlbrw_index]`.
- **Probe:**
  - Compare against `tlbp_entry_hi[31:13]` and `tlbp_entry_hi[7:0]`.
  - Hit: `tlbp_index = {0, i}`.
  - Miss: `tlbp_index = 32'h8000_0000` (P bit set).
  - Multiple hits: lowest index wins. The same priority applies on the lookup ports.
- **Segments:**
  - `vaddr[31:29]` = 3'b100 (kseg0): unmapped, `paddr = {3'b0, vaddr[28:0]}`, uncached = `kseg0_uncached`.
  - `vaddr[31:29]` = 3'b101 (kseg1): unmapped, same `paddr`, uncached = 1.
  - All other addresses are mapped. Matching uses `tlb_asid`.
- **Mapped results:**
  - `paddr = {pfn, vaddr[11:0]}`; uncached = (`c` != 3).
  - refill = no match.
  - invalid = match and !`v`.
  - mod (data port only) = match, `v`, `data_wr`, and !`d`.
  - The flags are mutually exclusive. Any flag set makes `paddr` don't-care.
- **Unmapped results:** all exception flags are 0.

## Timing
- **Lookup latency:** one cycle. A request sampled at edge N is visible after edge N.
  - Result registers load when `req && !stall`.
  - They hold when `stall=1`, or when `req=0`.
- **Reset values:** all result outputs are 0 (`paddr`=0, flags 0, uncached 0).
- **Write vs. lookup in the same cycle:**
  - A lookup in the same cycle as a TLBWI uses the old entry contents.
  - Lookups from the next cycle on see the new entry.
  - Probe and read in the write cycle also return old contents.
- **Reset mid-operation:** reset overrides the write and the result-register loads in that cycle.
- **TLBR/TLBP:** zero-cycle combinational. CP0 captures the result at the end of the same cycle.

## Structure
- `tlb_entry_t`, `tlb_index_t`, `virt_t`, `phys_t`, `` `TLB_ENTRIES_NUM `` and the segment base constants belong in the shared cpu package/header.
- Sub-module `tlb_lookup`:
  - Combinational match, priority-encode and page-select.
  - Inputs: the entry array, a vaddr and an asid.
  - Outputs: hit, index, pfn, c, d, v.
  - Instantiated three times: probe, instruction port, data port.
- The `tlb` top holds the entry storage, segment decode and result registers.

## Test plan
1. **TLBWI then fetch.** Write index 3 with vpn2=0x00400>>1, asid=5, pfn0=0x1234, c0=3, v0=1; `tlb_asid`=5; next cycle `inst_vaddr`=0x0040_0010. Required: one cycle later `inst_paddr`=0x0123_4010, `inst_uncached`=0, no flags.
2. **Probe hit and miss.**
   - `tlbp_entry_hi` = {vpn2 of entry 3, 5'b0, 8'd5} → `tlbp_index`=3.
   - Same with asid=6 and G=0 → `tlbp_index`=0x8000_0000.
   - Set G=1 → `tlbp_index`=3.
3. **Data faults.**
   - Odd page with v1=0, load → `data_invalid`=1.
   - v1=1, d1=0, `data_wr`=1 → `data_mod`=1.
   - Unmatched vpn2 → `data_refill`=1.
4. **Unmapped segments.**
   - 0x8000_1000 with `kseg0_uncached`=0 → paddr 0x0000_1000, uncached 0.
   - 0xA000_1000 → paddr 0x0000_1000, uncached 1, regardless of TLB contents.
5. **Write/lookup collision and stall.**
   - TLBWI changes pfn0 in the same cycle as a lookup → result uses the old pfn; the next lookup uses the new pfn.
   - `inst_stall`=1 while vaddr changes → outputs hold.
6. **Reset and TLBR.**
   - Reset → all outputs 0; any mapped lookup gives refill=1 or invalid=1, never a hit with valid.
   - TLBR of a written entry returns an identical `tlbrw_rdata`.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared TLB types: entry layout, index/address types and unmapped segment bases.
package tlb_pkg;

  localparam int unsigned TlbEntriesNum = 16;
  localparam int unsigned TlbIdxW       = $clog2(TlbEntriesNum);

  typedef logic [31:0]         virt_t;
  typedef logic [31:0]         phys_t;
  typedef logic [TlbIdxW-1:0]  tlb_index_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    phys_t paddr;
    logic  uncached;
    logic  refill;
    logic  invalid;
    logic  mod;
  } tlb_result_t;

  localparam logic [2:0] SegKseg0 = 3'b100;
  localparam logic [2:0] SegKseg1 = 3'b101;

endpackage

// File: rtl/tlb_lookup.sv
// Combinational match, lowest-index priority select and even/odd page select.
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter int unsigned TlbEntries = TlbEntriesNum
) (
  input  tlb_entry_t  entries_i [TlbEntries],
  input  virt_t       vaddr_i,
  input  logic [7:0]  asid_i,
  output logic        hit_o,
  output tlb_index_t  idx_o,
  output logic [19:0] pfn_o,
  output logic [2:0]  c_o,
  output logic        d_o,
  output logic        v_o
);

  tlb_entry_t sel;

  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    // Descending scan so the lowest matching index is the last one assigned.
    for (int i = int'(TlbEntries) - 1; i >= 0; i--) begin
      if (entries_i[i].vpn2 == vaddr_i[31:13] &&
          (entries_i[i].g || entries_i[i].asid == asid_i)) begin
        hit_o = 1'b1;
        idx_o = tlb_index_t'(i);
      end
    end
  end

  always_comb begin
    sel = entries_i[idx_o];
    if (vaddr_i[12]) begin
      pfn_o = sel.pfn1;
      c_o   = sel.c1;
      d_o   = sel.d1;
      v_o   = sel.v1;
    end else begin
      pfn_o = sel.pfn0;
      c_o   = sel.c0;
      d_o   = sel.d0;
      v_o   = sel.v0;
    end
  end

endmodule

// File: rtl/tlb.sv
// Joint TLB: entry storage, TLBR/TLBWI/TLBP and registered instruction/data translation.
module tlb
  import tlb_pkg::*;
#(
  parameter int unsigned TlbEntries = TlbEntriesNum
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  tlb_asid_i,
  input  tlb_index_t  tlbrw_index_i,
  input  logic        tlbrw_we_i,
  input  tlb_entry_t  tlbrw_wdata_i,
  output tlb_entry_t  tlbrw_rdata_o,
  input  logic [31:0] tlbp_entry_hi_i,
  output logic [31:0] tlbp_index_o,
  input  logic        kseg0_uncached_i,
  input  logic        inst_req_i,
  input  logic        inst_stall_i,
  input  virt_t       inst_vaddr_i,
  output phys_t       inst_paddr_o,
  output logic        inst_uncached_o,
  output logic        inst_refill_o,
  output logic        inst_invalid_o,
  input  logic        data_req_i,
  input  logic        data_stall_i,
  input  logic        data_wr_i,
  input  virt_t       data_vaddr_i,
  output phys_t       data_paddr_o,
  output logic        data_uncached_o,
  output logic        data_refill_o,
  output logic        data_invalid_o,
  output logic        data_mod_o
);

  tlb_entry_t  entries_q [TlbEntries];
  tlb_result_t inst_q, inst_d, data_q, data_d;

  logic        p_hit, i_hit, d_hit;
  tlb_index_t  p_idx, i_idx, d_idx;
  logic [19:0] p_pfn, i_pfn, d_pfn;
  logic [2:0]  p_c, i_c, d_c;
  logic        p_d, i_d, d_d;
  logic        p_v, i_v, d_v;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(TlbEntries); i++) begin
        entries_q[i].v0 <= 1'b0;
        entries_q[i].v1 <= 1'b0;
        entries_q[i].g  <= 1'b0;
      end
    end else if (tlbrw_we_i) begin
      entries_q[tlbrw_index_i] <= tlbrw_wdata_i;
    end
  end

  tlb_lookup #(.TlbEntries(TlbEntries)) u_probe (
    .entries_i(entries_q), .vaddr_i(tlbp_entry_hi_i), .asid_i(tlbp_entry_hi_i[7:0]),
    .hit_o(p_hit), .idx_o(p_idx), .pfn_o(p_pfn), .c_o(p_c), .d_o(p_d), .v_o(p_v)
  );

  tlb_lookup #(.TlbEntries(TlbEntries)) u_inst (
    .entries_i(entries_q), .vaddr_i(inst_vaddr_i), .asid_i(tlb_asid_i),
    .hit_o(i_hit), .idx_o(i_idx), .pfn_o(i_pfn), .c_o(i_c), .d_o(i_d), .v_o(i_v)
  );

  tlb_lookup #(.TlbEntries(TlbEntries)) u_data (
    .entries_i(entries_q), .vaddr_i(data_vaddr_i), .asid_i(tlb_asid_i),
    .hit_o(d_hit), .idx_o(d_idx), .pfn_o(d_pfn), .c_o(d_c), .d_o(d_d), .v_o(d_v)
  );

  assign tlbrw_rdata_o = entries_q[tlbrw_index_i];
  assign tlbp_index_o  = p_hit ? 32'(p_idx) : 32'h8000_0000;

  function automatic tlb_result_t xlate(virt_t va, logic wr, logic k0_unc, logic hit,
                                        logic [19:0] pfn, logic [2:0] c, logic d, logic v);
    tlb_result_t r;
    r = '0;
    if (va[31:29] == SegKseg0 || va[31:29] == SegKseg1) begin
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = (va[31:29] == SegKseg1) ? 1'b1 : k0_unc;
    end else begin
      r.paddr    = {pfn, va[11:0]};
      r.uncached = (c != 3'd3);
      r.refill   = !hit;
      r.invalid  = hit && !v;
      r.mod      = hit && v && wr && !d;
    end
    return r;
  endfunction

  always_comb begin
    inst_d = inst_q;
    data_d = data_q;
    if (inst_req_i && !inst_stall_i) begin
      inst_d     = xlate(inst_vaddr_i, 1'b0, kseg0_uncached_i, i_hit, i_pfn, i_c, i_d, i_v);
      inst_d.mod = 1'b0;
    end
    if (data_req_i && !data_stall_i) begin
      data_d = xlate(data_vaddr_i, data_wr_i, kseg0_uncached_i, d_hit, d_pfn, d_c, d_d, d_v);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inst_q <= '0;
      data_q <= '0;
    end else begin
      inst_q <= inst_d;
      data_q <= data_d;
    end
  end

  assign inst_paddr_o    = inst_q.paddr;
  assign inst_uncached_o = inst_q.uncached;
  assign inst_refill_o   = inst_q.refill;
  assign inst_invalid_o  = inst_q.invalid;

  assign data_paddr_o    = data_q.paddr;
  assign data_uncached_o = data_q.uncached;
  assign data_refill_o   = data_q.refill;
  assign data_invalid_o  = data_q.invalid;
  assign data_mod_o      = data_q.mod;

endmodule

// File: tb/tb_tlb.sv
// Randomized bench for tlb against a behavioural MIPS TLB model, plus directed cases.
module tb_tlb;
  import tlb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tlb_asid;
  tlb_index_t  tlbrw_index;
  logic        tlbrw_we;
  tlb_entry_t  tlbrw_wdata, tlbrw_rdata;
  logic [31:0] tlbp_entry_hi, tlbp_index;
  logic        kseg0_uncached;
  logic        inst_req, inst_stall;
  virt_t       inst_vaddr;
  phys_t       inst_paddr;
  logic        inst_uncached, inst_refill, inst_invalid;
  logic        data_req, data_stall, data_wr;
  virt_t       data_vaddr;
  phys_t       data_paddr;
  logic        data_uncached, data_refill, data_invalid, data_mod;

  tlb dut (
    .clk_i(clk), .reset_i(reset), .tlb_asid_i(tlb_asid),
    .tlbrw_index_i(tlbrw_index), .tlbrw_we_i(tlbrw_we), .tlbrw_wdata_i(tlbrw_wdata),
    .tlbrw_rdata_o(tlbrw_rdata), .tlbp_entry_hi_i(tlbp_entry_hi), .tlbp_index_o(tlbp_index),
    .kseg0_uncached_i(kseg0_uncached),
    .inst_req_i(inst_req), .inst_stall_i(inst_stall), .inst_vaddr_i(inst_vaddr),
    .inst_paddr_o(inst_paddr), .inst_uncached_o(inst_uncached),
    .inst_refill_o(inst_refill), .inst_invalid_o(inst_invalid),
    .data_req_i(data_req), .data_stall_i(data_stall), .data_wr_i(data_wr),
    .data_vaddr_i(data_vaddr), .data_paddr_o(data_paddr), .data_uncached_o(data_uncached),
    .data_refill_o(data_refill), .data_invalid_o(data_invalid), .data_mod_o(data_mod)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference state: the architectural TLB contents and the pending port results.
  tlb_entry_t  model [TlbEntriesNum];
  logic        known;
  tlb_result_t exp_i, exp_d;
  logic        fo_i, fo_d;

  function automatic logic [31:0] model_probe(logic [31:0] ehi);
    for (int i = 0; i < int'(TlbEntriesNum); i++)
      if (model[i].vpn2 == ehi[31:13] && (model[i].g || model[i].asid == ehi[7:0]))
        return 32'(i);
    return 32'h8000_0000;
  endfunction

  function automatic tlb_result_t model_xlate(virt_t va, logic wr, logic [7:0] asid,
                                              logic k0u, logic is_data);
    tlb_result_t r;
    r = '0;
    if (va >= 32'h8000_0000 && va < 32'hC000_0000) begin
      r.paddr    = va - (va >= 32'hA000_0000 ? 32'hA000_0000 : 32'h8000_0000);
      r.uncached = (va >= 32'hA000_0000) ? 1'b1 : k0u;
      return r;
    end
    r.refill = 1'b1;
    for (int i = 0; i < int'(TlbEntriesNum); i++) begin
      if (model[i].vpn2 == va[31:13] && (model[i].g || model[i].asid == asid)) begin
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d, v;
        pfn = va[12] ? model[i].pfn1 : model[i].pfn0;
        c   = va[12] ? model[i].c1   : model[i].c0;
        d   = va[12] ? model[i].d1   : model[i].d0;
        v   = va[12] ? model[i].v1   : model[i].v0;
        r.refill   = 1'b0;
        r.paddr    = pfn * 32'h1000 + (va % 32'h1000);
        r.uncached = (c != 3'd3);
        r.invalid  = !v;
        r.mod      = is_data && v && wr && !d;
        return r;
      end
    end
    return r;
  endfunction

  function automatic logic [18:0] pick_vpn2();
    return $urandom_range(0, 1) ? 19'($urandom_range(0, 7)) : 19'h60000 + 19'($urandom_range(0, 7));
  endfunction

  function automatic tlb_entry_t rand_entry();
    tlb_entry_t e;
    e = tlb_entry_t'({$urandom, $urandom, $urandom});
    e.vpn2 = pick_vpn2();
    e.asid = 8'($urandom_range(0, 3));
    e.g    = ($urandom_range(0, 3) == 0);
    return e;
  endfunction

  function automatic virt_t rand_vaddr();
    int unsigned r = $urandom_range(0, 9);
    if (r == 0) return {3'b100, 29'($urandom)};
    if (r == 1) return {3'b101, 29'($urandom)};
    return {pick_vpn2(), 13'($urandom)};
  endfunction

  task automatic cmp_port(input string p, input tlb_result_t exp, input logic fo,
                          input phys_t pa, input logic unc, input logic rf, input logic inv,
                          input logic md);
    if (fo) begin
      chk({p, "_fault_after_reset"}, 128'(rf | inv), 128'(1'b1));
    end else begin
      chk({p, "_refill"},  128'(rf),  128'(exp.refill));
      chk({p, "_invalid"}, 128'(inv), 128'(exp.invalid));
      chk({p, "_mod"},     128'(md),  128'(exp.mod));
      if (!(exp.refill || exp.invalid || exp.mod)) begin
        chk({p, "_paddr"},    128'(pa),  128'(exp.paddr));
        chk({p, "_uncached"}, 128'(unc), 128'(exp.uncached));
      end
    end
  endtask

  // Inputs are set before the call (negedge phase); checks combinational paths, clocks
  // once, updates the model and compares the registered results at the next negedge.
  task automatic step();
    tlb_result_t ni, nd;
    logic        nfi, nfd, mapped;
    #1;
    if (known) begin
      chk("tlbp_index", 128'(tlbp_index), 128'(model_probe(tlbp_entry_hi)));
      chk("tlbr_rdata", 128'(tlbrw_rdata), 128'(model[tlbrw_index]));
    end
    ni = exp_i; nd = exp_d; nfi = fo_i; nfd = fo_d;
    if (reset) begin
      ni = '0; nd = '0; nfi = 1'b0; nfd = 1'b0;
    end else begin
      if (inst_req && !inst_stall) begin
        ni = model_xlate(inst_vaddr, 1'b0, tlb_asid, kseg0_uncached, 1'b0);
        mapped = !(inst_vaddr >= 32'h8000_0000 && inst_vaddr < 32'hC000_0000);
        nfi = !known && mapped;
      end
      if (data_req && !data_stall) begin
        nd = model_xlate(data_vaddr, data_wr, tlb_asid, kseg0_uncached, 1'b1);
        mapped = !(data_vaddr >= 32'h8000_0000 && data_vaddr < 32'hC000_0000);
        nfd = !known && mapped;
      end
    end
    @(posedge clk);
    if (reset) begin
      known = 1'b0;
      for (int i = 0; i < int'(TlbEntriesNum); i++) begin
        model[i].v0 = 1'b0; model[i].v1 = 1'b0; model[i].g = 1'b0;
      end
    end else if (tlbrw_we) begin
      model[tlbrw_index] = tlbrw_wdata;
    end
    exp_i = ni; exp_d = nd; fo_i = nfi; fo_d = nfd;
    @(negedge clk);
    cmp_port("inst", exp_i, fo_i, inst_paddr, inst_uncached, inst_refill, inst_invalid, 1'b0);
    cmp_port("data", exp_d, fo_d, data_paddr, data_uncached, data_refill, data_invalid, data_mod);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; tlbrw_we = 1'b0; inst_req = 1'b0; inst_stall = 1'b0;
    data_req = 1'b0; data_stall = 1'b0; data_wr = 1'b0;
  endtask

  tlb_entry_t e3, e4;

  initial begin
    known = 1'b0; exp_i = '0; exp_d = '0; fo_i = 1'b0; fo_d = 1'b0;
    for (int i = 0; i < int'(TlbEntriesNum); i++) model[i] = '0;
    idle_inputs();
    reset = 1'b1; tlb_asid = 8'd0; tlbrw_index = '0; tlbrw_wdata = '0;
    tlbp_entry_hi = '0; kseg0_uncached = 1'b0; inst_vaddr = '0; data_vaddr = '0;
    @(negedge clk);
    step(); step();
    chk("reset_inst_paddr", 128'(inst_paddr), 128'(0));
    chk("reset_data_flags", 128'({data_uncached, data_refill, data_invalid, data_mod}), 128'(0));

    // Mapped lookups straight after reset must fault.
    reset = 1'b0; inst_req = 1'b1; inst_vaddr = 32'h0040_0010;
    data_req = 1'b1; data_vaddr = 32'h0060_1000;
    step();
    idle_inputs();

    // Populate every entry, then mark the model fully known.
    for (int i = 0; i < int'(TlbEntriesNum); i++) begin
      tlbrw_we = 1'b1; tlbrw_index = tlb_index_t'(i); tlbrw_wdata = rand_entry();
      step();
    end
    tlbrw_we = 1'b0; known = 1'b1;

    // TLBWI then fetch.
    e3 = '0; e3.vpn2 = 19'h200; e3.asid = 8'd5; e3.pfn0 = 20'h1234; e3.c0 = 3'd3; e3.v0 = 1'b1;
    tlb_asid = 8'd5; tlbrw_we = 1'b1; tlbrw_index = 4'd3; tlbrw_wdata = e3;
    step();
    tlbrw_we = 1'b0; inst_req = 1'b1; inst_vaddr = 32'h0040_0010;
    step();
    chk("t1_paddr", 128'(inst_paddr), 128'(32'h0123_4010));
    chk("t1_flags", 128'({inst_uncached, inst_refill, inst_invalid}), 128'(0));

    // Probe hit, asid miss, global hit.
    tlbp_entry_hi = {19'h200, 5'b0, 8'd5}; #1;
    chk("t2_probe_hit", 128'(tlbp_index), 128'(32'd3));
    tlbp_entry_hi = {19'h200, 5'b0, 8'd6}; #1;
    chk("t2_probe_miss", 128'(tlbp_index), 128'(32'h8000_0000));
    e3.g = 1'b1; tlbrw_we = 1'b1; tlbrw_wdata = e3;
    step();
    tlbrw_we = 1'b0; #1;
    chk("t2_probe_global", 128'(tlbp_index), 128'(32'd3));

    // Data faults on entry 4's odd page.
    e4 = '0; e4.vpn2 = 19'h300; e4.asid = 8'd5; e4.pfn1 = 20'hABCDE; e4.c1 = 3'd2;
    tlbrw_we = 1'b1; tlbrw_index = 4'd4; tlbrw_wdata = e4;
    step();
    tlbrw_we = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_vaddr = 32'h0060_1000;
    step();
    chk("t3_invalid", 128'({data_refill, data_invalid, data_mod}), 128'(3'b010));
    e4.v1 = 1'b1; tlbrw_we = 1'b1; tlbrw_wdata = e4;
    step();
    tlbrw_we = 1'b0; data_wr = 1'b1;
    step();
    chk("t3_mod", 128'({data_refill, data_invalid, data_mod}), 128'(3'b001));
    data_vaddr = 32'h0060_3000;
    step();
    chk("t3_refill", 128'({data_refill, data_invalid, data_mod}), 128'(3'b100));

    // Unmapped segments.
    kseg0_uncached = 1'b0; inst_vaddr = 32'h8000_1000; data_vaddr = 32'hA000_1000;
    step();
    chk("t4_k0", 128'({inst_paddr, inst_uncached}), 128'({32'h0000_1000, 1'b0}));
    chk("t4_k1", 128'({data_paddr, data_uncached, data_mod}), 128'({32'h0000_1000, 2'b10}));

    // Write/lookup collision, then stall hold.
    inst_vaddr = 32'h0040_0010; e3.pfn0 = 20'h5678;
    tlbrw_we = 1'b1; tlbrw_index = 4'd3; tlbrw_wdata = e3;
    step();
    chk("t5_old_pfn", 128'(inst_paddr), 128'(32'h0123_4010));
    tlbrw_we = 1'b0;
    step();
    chk("t5_new_pfn", 128'(inst_paddr), 128'(32'h0567_8010));
    inst_stall = 1'b1; inst_vaddr = 32'h8000_2000;
    step();
    chk("t5_stall_hold", 128'(inst_paddr), 128'(32'h0567_8010));
    inst_stall = 1'b0;

    // TLBR returns the written entry.
    tlbrw_index = 4'd3; #1;
    chk("t6_tlbr", 128'(tlbrw_rdata), 128'(e3));

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      tlbrw_we       = ($urandom_range(0, 5) == 0);
      tlbrw_index    = tlb_index_t'($urandom);
      tlbrw_wdata    = rand_entry();
      tlb_asid       = 8'($urandom_range(0, 3));
      tlbp_entry_hi  = {pick_vpn2(), 5'($urandom), 8'($urandom_range(0, 3))};
      kseg0_uncached = 1'($urandom);
      inst_req       = ($urandom_range(0, 4) != 0);
      inst_stall     = ($urandom_range(0, 4) == 0);
      inst_vaddr     = rand_vaddr();
      data_req       = ($urandom_range(0, 4) != 0);
      data_stall     = ($urandom_range(0, 4) == 0);
      data_wr        = 1'($urandom);
      data_vaddr     = rand_vaddr();
      step();
    end

    // Reset overrides a simultaneous write and result loads.
    reset = 1'b1; tlbrw_we = 1'b1; inst_req = 1'b1; data_req = 1'b1;
    inst_vaddr = 32'h8000_1234; data_vaddr = 32'hA000_5678;
    step();
    chk("reset_mid_op", 128'({inst_paddr, data_paddr, inst_uncached, data_uncached}), 128'(0));
    idle_inputs();
    inst_req = 1'b1; inst_vaddr = {pick_vpn2(), 13'($urandom)};
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
